mc_controller: RTL and testbench
================================

Name: mc_controller

Overview:
- Main control FSM plus ALU decoder for the multicycle MIPS datapath. It is the multicycle successor to the single-cycle core and shares one memory for instructions and data.
- Takes opcode, funct and ALU zero from the datapath. Drives every mux select and write enable, one microstep per clock.
- Sits inside the multicycle core next to the datapath. The top level keeps the same write_data, data_adr and mem_write bench contract as the single-cycle core.

Parameters:
- SUPPORT_BNE, default 1: when 1, op 000101 is decoded as bne; when 0 it is treated as an illegal op.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- op  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- pc_en  out  1  PC register enable: pc_write | (branch & (zero ^ bne_sel)).
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
- mem_write  out  1  memory write enable.
- ir_write  out  1  instruction register enable.
- reg_dst  out  1  register write address select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  register write data select: 0 = ALUOut, 1 = Data register.
- reg_write  out  1  register file write enable.
- alu_src_a  out  1  ALU input A select: 0 = PC, 1 = A.
- alu_src_b  out  2  ALU input B select: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- pc_src  out  2  next-PC select: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- alu_control  out  3  ALU operation: 010 add, 110 sub, 000 and, 001 or, 111 slt, 011 sll.
- illegal_op  out  1  one-cycle pulse in DECODE when op is unrecognised.
- state_dbg  out  4  current state encoding, for debug.

Behaviour:
- State register: Moore outputs decoded from the current state. alu_control is combinational from (alu_op, funct).
- Reset asserted: state = FETCH immediately, asynchronously.
  - pc_en, mem_write, ir_write, reg_write and illegal_op are forced to 0 while reset = 0.
  - Other outputs take their FETCH values.
  - Reset mid-instruction abandons that instruction; no partial register or memory write occurs after reset asserts.
- States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEXEC 9, ADDIWB 10, JUMP 11.
- Per-state outputs (anything not listed is 0 / don't-care-as-0):
  - FETCH: iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_src=00, ir_write=1, pc_write=1. Next state DECODE.
  - DECODE: alu_src_a=0, alu_src_b=11, alu_op=add. Next state by op:
    - 100011 (lw) or 101011 (sw) -> MEMADR.
    - 000000 (R-type) -> EXECUTE.
    - 000100 (beq) -> BRANCH.
    - 000101 (bne, when SUPPORT_BNE) -> BRANCH.
    - 001000 (addi) -> ADDIEXEC.
    - 000010 (j) -> JUMP.
    - any other op -> FETCH, with illegal_op=1 for this one cycle.
  - MEMADR: alu_src_a=1, alu_src_b=10, alu_op=add. lw -> MEMRD; sw -> MEMWR.
  - MEMRD: iord=1. Next MEMWB.
  - MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1. Next FETCH.
  - MEMWR: iord=1, mem_write=1. Next FETCH.
  - EXECUTE: alu_src_a=1, alu_src_b=00, alu_op=funct. Next ALUWB.
  - ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1. Next FETCH.
  - BRANCH: alu_src_a=1, alu_src_b=00, alu_op=sub, pc_src=01, branch=1. bne_sel=1 only for bne. Next FETCH.
  - ADDIEXEC: alu_src_a=1, alu_src_b=10, alu_op=add. Next ADDIWB.
  - ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1. Next FETCH.
  - JUMP: pc_src=10, pc_write=1. Next FETCH.
- ALU decoder:
  - alu_op=add -> 010; alu_op=sub -> 110.
  - alu_op=funct maps funct 100000 -> 010, 100010 -> 110, 100100 -> 000, 100101 -> 001, 101010 -> 111, 000000 (sll) -> 011.
  - Unknown funct -> 010. The instruction still completes through ALUWB; no illegal_op is raised.
- Instruction latency in cycles: lw 5; sw, R-type and addi 4; beq, bne and j 3; illegal op 2.
- Unused state encodings 12-15 go to FETCH on the next edge, with all enables 0 in those states.

Decomposition:
- mc_pkg holds:
  - state_t enum (4-bit, encodings as above);
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J;
  - funct constants;
  - alu_op_t {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT};
  - ALU control constants.
- One sub-module, alu_decoder: purely combinational, mapping (alu_op, funct) -> alu_control.

Test Plan:
- Reset: hold reset=0 for 22 ns, then release -> all enables 0 during reset, state_dbg=0. First rising edge after release shows ir_write=1 and pc_en=1.
- lw (op=100011) -> state_dbg sequence 0,1,2,3,4,0. In state 3, iord=1. In state 4, reg_write=1 and mem_to_reg=1. mem_write stays 0 throughout.
- sw (op=101011) -> sequence 0,1,2,5,0. mem_write=1 and iord=1 only in state 5.
- R-type add then sll (op=0, funct=100000, then funct=000000) -> alu_control=010 in EXECUTE for add, 011 for sll. ALUWB has reg_dst=1 and reg_write=1.
- beq with zero=1, then zero=0 -> pc_en=1 in BRANCH for the first, 0 for the second. bne (SUPPORT_BNE=1) gives the inverse. Both return to FETCH after 3 cycles.
- Illegal op 111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH, with no write enable asserted. Separately, driving reset=0 during MEMRD of a lw -> immediate return to FETCH, with no MEMWB reg_write.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller:
// FSM state encodings, opcode/funct values, ALU op classes and ALU control codes.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWR    = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BRANCH   = 4'd8,
      S_ADDIEXEC = 4'd9,
      S_ADDIWB   = 4'd10,
      S_JUMP     = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD = 6'b100000;
   localparam logic [5:0] FUNCT_SUB = 6'b100010;
   localparam logic [5:0] FUNCT_AND = 6'b100100;
   localparam logic [5:0] FUNCT_OR  = 6'b100101;
   localparam logic [5:0] FUNCT_SLT = 6'b101010;
   localparam logic [5:0] FUNCT_SLL = 6'b000000;

   typedef enum logic [1:0] {
      ALUOP_ADD   = 2'd0,
      ALUOP_SUB   = 2'd1,
      ALUOP_FUNCT = 2'd2
   } alu_op_t;

   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_SLT = 3'b111;
   localparam logic [2:0] ALUC_SLL = 3'b011;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps the FSM's ALU op class and the funct field
// to the 3-bit ALU operation code.
module alu_decoder
   import mc_pkg::*;
(
   input  alu_op_t     alu_op,
   input  logic [5:0]  funct,
   output logic [2:0]  alu_control
);

   always_comb begin
      alu_control = ALUC_ADD;
      case (alu_op)
         ALUOP_ADD: alu_control = ALUC_ADD;
         ALUOP_SUB: alu_control = ALUC_SUB;
         ALUOP_FUNCT: begin
            // Unrecognised funct falls back to add; the R-type still completes.
            case (funct)
               FUNCT_ADD: alu_control = ALUC_ADD;
               FUNCT_SUB: alu_control = ALUC_SUB;
               FUNCT_AND: alu_control = ALUC_AND;
               FUNCT_OR:  alu_control = ALUC_OR;
               FUNCT_SLT: alu_control = ALUC_SLT;
               FUNCT_SLL: alu_control = ALUC_SLL;
               default:   alu_control = ALUC_ADD;
            endcase
         end
         default: alu_control = ALUC_ADD;
      endcase
   end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main control FSM: one microstep per clock, Moore outputs
// decoded from the state register, write enables gated off while reset is low.
module mc_controller
   import mc_pkg::*;
#(
   parameter bit SUPPORT_BNE = 1'b1
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  op,
   input  logic [5:0]  funct,
   input  logic        zero,
   output logic        pc_en,
   output logic        iord,
   output logic        mem_write,
   output logic        ir_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        reg_write,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_src,
   output logic [2:0]  alu_control,
   output logic        illegal_op,
   output logic [3:0]  state_dbg
);

   state_t  state;
   alu_op_t alu_op;
   logic    op_known;
   logic    pc_write;
   logic    branch;
   logic    bne_sel;
   logic    mem_write_raw;
   logic    ir_write_raw;
   logic    reg_write_raw;

   always_comb begin
      op_known = (op == OP_LW)   || (op == OP_SW)   || (op == OP_RTYPE) ||
                 (op == OP_BEQ)  || (op == OP_ADDI) || (op == OP_J)     ||
                 (SUPPORT_BNE && (op == OP_BNE));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               if (!op_known)
                  state <= S_FETCH;
               else if ((op == OP_LW) || (op == OP_SW))
                  state <= S_MEMADR;
               else if (op == OP_RTYPE)
                  state <= S_EXECUTE;
               else if ((op == OP_BEQ) || (op == OP_BNE))
                  state <= S_BRANCH;
               else if (op == OP_ADDI)
                  state <= S_ADDIEXEC;
               else
                  state <= S_JUMP;
            end
            S_MEMADR:   state <= (op == OP_LW) ? S_MEMRD : ((op == OP_SW) ? S_MEMWR : S_FETCH);
            S_MEMRD:    state <= S_MEMWB;
            S_EXECUTE:  state <= S_ALUWB;
            S_ADDIEXEC: state <= S_ADDIWB;
            // Writeback, branch, jump and unused encodings all return to FETCH.
            default:    state <= S_FETCH;
         endcase
      end
   end

   always_comb begin
      iord          = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      pc_src        = 2'b00;
      alu_op        = ALUOP_ADD;
      pc_write      = 1'b0;
      branch        = 1'b0;
      mem_write_raw = 1'b0;
      ir_write_raw  = 1'b0;
      reg_write_raw = 1'b0;
      case (state)
         S_FETCH: begin
            alu_src_b    = 2'b01;
            ir_write_raw = 1'b1;
            pc_write     = 1'b1;
         end
         S_DECODE:   alu_src_b = 2'b11;
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEMRD:    iord = 1'b1;
         S_MEMWB: begin
            mem_to_reg    = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_MEMWR: begin
            iord          = 1'b1;
            mem_write_raw = 1'b1;
         end
         S_EXECUTE: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            reg_dst       = 1'b1;
            reg_write_raw = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALUOP_SUB;
            pc_src    = 2'b01;
            branch    = 1'b1;
         end
         S_ADDIEXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_ADDIWB:   reg_write_raw = 1'b1;
         S_JUMP: begin
            pc_src   = 2'b10;
            pc_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign bne_sel = SUPPORT_BNE && (op == OP_BNE);

   // Enables are masked by reset directly so nothing fires while it is held.
   assign pc_en      = reset & (pc_write | (branch & (zero ^ bne_sel)));
   assign mem_write  = reset & mem_write_raw;
   assign ir_write   = reset & ir_write_raw;
   assign reg_write  = reset & reg_write_raw;
   assign illegal_op = reset & (state == S_DECODE) & ~op_known;
   assign state_dbg  = state;

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (funct),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its
// state sequence and compares outputs against hand-computed values.
module tb_mc_controller;

   logic        clk;
   logic        reset;
   logic [5:0]  op;
   logic [5:0]  funct;
   logic        zero;
   logic        pc_en;
   logic        iord;
   logic        mem_write;
   logic        ir_write;
   logic        reg_dst;
   logic        mem_to_reg;
   logic        reg_write;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  pc_src;
   logic [2:0]  alu_control;
   logic        illegal_op;
   logic [3:0]  state_dbg;

   int n_checks = 0;
   int n_errors = 0;

   mc_controller #(.SUPPORT_BNE(1'b1)) dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct       (funct),
      .zero        (zero),
      .pc_en       (pc_en),
      .iord        (iord),
      .mem_write   (mem_write),
      .ir_write    (ir_write),
      .reg_dst     (reg_dst),
      .mem_to_reg  (mem_to_reg),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .pc_src      (pc_src),
      .alu_control (alu_control),
      .illegal_op  (illegal_op),
      .state_dbg   (state_dbg)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step_state(input string tag, input logic [3:0] exp_state);
      @(negedge clk);
      check(tag, state_dbg, exp_state);
   endtask

   task automatic check_no_writes(input string tag);
      check({tag, "_pc_en"}, pc_en, 0);
      check({tag, "_mem_write"}, mem_write, 0);
      check({tag, "_ir_write"}, ir_write, 0);
      check({tag, "_reg_write"}, reg_write, 0);
   endtask

   task automatic start_instr(input logic [5:0] o, input logic [5:0] f, input logic z);
      op = o;
      funct = f;
      zero = z;
   endtask

   task automatic run_branch(input string tag, input logic [5:0] o, input logic z, input logic exp_pc_en);
      start_instr(o, 6'b0, z);
      step_state({tag, "_decode"}, 4'd1);
      step_state({tag, "_branch"}, 4'd8);
      check({tag, "_pc_en"}, pc_en, exp_pc_en);
      check({tag, "_pc_src"}, pc_src, 2'b01);
      check({tag, "_aluc"}, alu_control, 3'b110);
      step_state({tag, "_fetch"}, 4'd0);
   endtask

   task automatic run_rtype(input string tag, input logic [5:0] f, input logic [2:0] exp_aluc);
      start_instr(6'b000000, f, 1'b0);
      step_state({tag, "_decode"}, 4'd1);
      step_state({tag, "_exec"}, 4'd6);
      check({tag, "_aluc"}, alu_control, exp_aluc);
      check({tag, "_src_a"}, alu_src_a, 1);
      check({tag, "_illegal"}, illegal_op, 0);
      step_state({tag, "_aluwb"}, 4'd7);
      check({tag, "_reg_dst"}, reg_dst, 1);
      check({tag, "_reg_write"}, reg_write, 1);
      step_state({tag, "_fetch"}, 4'd0);
   endtask

   initial begin
      reset = 1'b0;
      start_instr(6'b100011, 6'b0, 1'b0);

      // reset held: FETCH, enables low, FETCH mux values
      #10;
      check("rst_state", state_dbg, 4'd0);
      check_no_writes("rst");
      check("rst_illegal", illegal_op, 0);
      check("rst_src_b", alu_src_b, 2'b01);
      #12 reset = 1'b1;
      #1;
      check("rel_state", state_dbg, 4'd0);
      check("rel_ir_write", ir_write, 1);
      check("rel_pc_en", pc_en, 1);
      check("rel_iord", iord, 0);
      check("rel_aluc", alu_control, 3'b010);

      // lw: 0,1,2,3,4,0
      step_state("lw_decode", 4'd1);
      check("lw_dec_src_b", alu_src_b, 2'b11);
      check("lw_dec_mw", mem_write, 0);
      step_state("lw_memadr", 4'd2);
      check("lw_adr_src_a", alu_src_a, 1);
      check("lw_adr_src_b", alu_src_b, 2'b10);
      check("lw_adr_mw", mem_write, 0);
      step_state("lw_memrd", 4'd3);
      check("lw_rd_iord", iord, 1);
      check("lw_rd_mw", mem_write, 0);
      step_state("lw_memwb", 4'd4);
      check("lw_wb_reg_write", reg_write, 1);
      check("lw_wb_mem_to_reg", mem_to_reg, 1);
      check("lw_wb_reg_dst", reg_dst, 0);
      check("lw_wb_mw", mem_write, 0);
      step_state("lw_fetch", 4'd0);

      // sw: 0,1,2,5,0
      start_instr(6'b101011, 6'b0, 1'b0);
      step_state("sw_decode", 4'd1);
      check("sw_dec_mw", mem_write, 0);
      step_state("sw_memadr", 4'd2);
      check("sw_adr_mw", mem_write, 0);
      step_state("sw_memwr", 4'd5);
      check("sw_wr_mw", mem_write, 1);
      check("sw_wr_iord", iord, 1);
      check("sw_wr_reg_write", reg_write, 0);
      step_state("sw_fetch", 4'd0);
      check("sw_fetch_mw", mem_write, 0);
      check("sw_fetch_iord", iord, 0);

      // R-type: add, sll, slt, unknown funct
      run_rtype("add", 6'b100000, 3'b010);
      run_rtype("sll", 6'b000000, 3'b011);
      run_rtype("slt", 6'b101010, 3'b111);
      run_rtype("or",  6'b100101, 3'b001);
      run_rtype("unk", 6'b111111, 3'b010);

      // branches
      run_branch("beq_taken", 6'b000100, 1'b1, 1'b1);
      run_branch("beq_not",   6'b000100, 1'b0, 1'b0);
      run_branch("bne_not",   6'b000101, 1'b1, 1'b0);
      run_branch("bne_taken", 6'b000101, 1'b0, 1'b1);

      // addi: 0,1,9,10,0
      start_instr(6'b001000, 6'b0, 1'b0);
      step_state("addi_decode", 4'd1);
      step_state("addi_exec", 4'd9);
      check("addi_src_b", alu_src_b, 2'b10);
      check("addi_aluc", alu_control, 3'b010);
      step_state("addi_wb", 4'd10);
      check("addi_reg_write", reg_write, 1);
      check("addi_reg_dst", reg_dst, 0);
      check("addi_mem_to_reg", mem_to_reg, 0);
      step_state("addi_fetch", 4'd0);

      // j: 0,1,11,0
      start_instr(6'b000010, 6'b0, 1'b0);
      step_state("j_decode", 4'd1);
      step_state("j_jump", 4'd11);
      check("j_pc_en", pc_en, 1);
      check("j_pc_src", pc_src, 2'b10);
      step_state("j_fetch", 4'd0);

      // illegal op: one-cycle pulse in DECODE, then FETCH
      start_instr(6'b111111, 6'b0, 1'b0);
      check("ill_fetch_pulse", illegal_op, 0);
      step_state("ill_decode", 4'd1);
      check("ill_pulse", illegal_op, 1);
      check_no_writes("ill_dec");
      step_state("ill_fetch", 4'd0);
      check("ill_pulse_end", illegal_op, 0);

      // reset during MEMRD of lw
      start_instr(6'b100011, 6'b0, 1'b0);
      step_state("rlw_decode", 4'd1);
      step_state("rlw_memadr", 4'd2);
      step_state("rlw_memrd", 4'd3);
      reset = 1'b0;
      #1;
      check("rlw_state", state_dbg, 4'd0);
      check_no_writes("rlw_rst");
      @(negedge clk);
      check("rlw_hold_state", state_dbg, 4'd0);
      check("rlw_hold_reg_write", reg_write, 0);
      reset = 1'b1;
      #1;
      check("rlw_rel_state", state_dbg, 4'd0);
      check("rlw_rel_reg_write", reg_write, 0);
      check("rlw_rel_ir_write", ir_write, 1);
      step_state("rlw_restart", 4'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
